// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
package fetch_pkg;
   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
   localparam int ADDR_W_DEF = 16;
   localparam int INSTR_W_DEF = 16;
   localparam logic [3:0] HALT_OP = 4'hF;
   localparam logic [15:0] NOP = 16'hA000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-2 synchronous FIFO with flush and occupancy count.
module fetch_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [W-1:0]          din,
   output logic [W-1:0]          dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic do_push, do_pop;
   assign do_pop = pop && count != '0;
   assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
   assign dout = mem[rd];
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else if (flush) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         wr <= wr + AW'(do_push);
         rd <= rd + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: in-order fetch with decode queue, redirect flush and HLT stop.
// FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH = 4,
   parameter int PC_STEP = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0] HALT_OPCODE = HALT_OP
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [INSTR_W-1:0]       imem_rdata,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [INSTR_W-1:0]       dec_instr,
   output logic [ADDR_W-1:0]        dec_pc,
   output logic [ADDR_W-1:0]        dec_pc_inc,
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int OW = $clog2(DEPTH) + 1;
   state_t state;
   logic [ADDR_W-1:0] fetch_pc, a_head, q_pc;
   logic [INSTR_W-1:0] q_instr;
   logic [INSTR_W+ADDR_W-1:0] q_dout;
   logic [OW-1:0] outstanding, drop_cnt;
   logic [OW:0] credit;
   logic q_valid, keep, byp, push, pop, grant;
   // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow
   assign credit = {1'b0, occupancy} + {1'b0, outstanding};
   assign imem_req = !rst && state == RUN && !redirect_valid && drop_cnt == '0 && credit < (OW+1)'(DEPTH);
   assign imem_addr = fetch_pc;
   assign grant = imem_req && imem_gnt;
   assign keep = imem_rvalid && drop_cnt == '0 && !redirect_valid;
`ifdef FETCH_BYPASS_EN
   assign byp = keep && !q_valid;
`else
   assign byp = 1'b0;
`endif
   assign q_valid = occupancy != '0;
   assign {q_instr, q_pc} = q_dout;
   assign push = keep && !(byp && dec_ready);
   assign pop = q_valid && dec_ready && !redirect_valid;
   assign dec_valid = q_valid || byp;
   assign dec_instr = q_valid ? q_instr : byp ? imem_rdata : '0;
   assign dec_pc = q_valid ? q_pc : byp ? a_head : '0;
   assign dec_pc_inc = dec_pc + ADDR_W'(PC_STEP);
   assign halted = state == HALTED;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= RUN;
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         state <= RUN;
         fetch_pc <= redirect_pc;
         drop_cnt <= outstanding - OW'(imem_rvalid);
      end else begin
         if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
         if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
         if (keep && imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE) state <= HALTED;
      end
   fetch_fifo #(.W(INSTR_W + ADDR_W), .DEPTH(DEPTH)) data_q (
      .clk(clk), .rst(rst), .flush(redirect_valid), .push(push), .pop(pop),
      .din({imem_rdata, a_head}), .dout(q_dout), .count(occupancy)
   );
   // Every response, kept or dropped, retires the oldest in-flight address
   fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) addr_q (
      .clk(clk), .rst(rst), .flush(1'b0), .push(grant), .pop(imem_rvalid),
      .din(fetch_pc), .dout(a_head), .count(outstanding)
   );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of fetch, stall, redirect, halt, wrap and reset.
module tb_fetch_queue_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_req, imem_gnt, imem_rvalid, redirect_valid, dec_valid, dec_ready, halted;
   logic [15:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc, dec_pc_inc;
   logic [2:0] occupancy;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int lat = 1;
   logic [15:0] hlt_addr = 16'h0001;
   typedef struct {logic [15:0] a; int due;} rsp_t;
   rsp_t pq[$];
   always #5 clk = ~clk;
   fetch_queue_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_inc(dec_pc_inc), .halted(halted),
      .occupancy(occupancy)
   );
   function automatic logic [15:0] word(logic [15:0] a);
      return (a == hlt_addr) ? 16'hF000 : {4'h1, a[11:0]};
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive();
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      if (pq.size() > 0 && pq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata = word(pq[0].a);
         void'(pq.pop_front());
      end
      #1;
   endtask
   task automatic tick();
      logic r;
      logic [15:0] a;
      #1;
      r = imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      if (r) pq.push_back('{a, cyc + lat});
      cyc++;
      @(negedge clk);
      drive();
   endtask
   task automatic ticks(int n);
      repeat (n) tick();
   endtask
   task automatic do_reset(int l, logic r);
      rst = 1'b1;
      redirect_valid = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      dec_ready = r;
      lat = l;
      pq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      #1;
   endtask
   initial begin
      imem_gnt = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      dec_ready = 1'b1;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", dec_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_instr", dec_instr, 0);
      chk("rst_pc", dec_pc, 0);
      // streaming fetch, latency 1
      do_reset(1, 1'b1);
      chk("t1_req0", imem_req, 1);
      chk("t1_addr0", imem_addr, 16'h0000);
      tick();
      chk("t1_addr1", imem_addr, 16'h0002);
      chk("t1_nvalid", dec_valid, 0);
      tick();
      chk("t1_addr2", imem_addr, 16'h0004);
      chk("t1_valid", dec_valid, 1);
      chk("t1_pc0", dec_pc, 16'h0000);
      chk("t1_inc0", dec_pc_inc, 16'h0002);
      chk("t1_instr0", dec_instr, 16'h1000);
      tick();
      chk("t1_pc1", dec_pc, 16'h0002);
      chk("t1_inc1", dec_pc_inc, 16'h0004);
      tick();
      chk("t1_pc2", dec_pc, 16'h0004);
      chk("t1_inc2", dec_pc_inc, 16'h0006);
      // decode stall fills the queue
      do_reset(1, 1'b0);
      ticks(5);
      chk("t2_occ4", occupancy, 4);
      chk("t2_noreq", imem_req, 0);
      chk("t2_head", dec_pc, 16'h0000);
      ticks(2);
      chk("t2_occ_hold", occupancy, 4);
      chk("t2_noreq_hold", imem_req, 0);
      dec_ready = 1'b1;
      chk("t2_pop0", dec_pc, 16'h0000);
      tick();
      chk("t2_pop1", dec_pc, 16'h0002);
      chk("t2_resume", imem_req, 1);
      chk("t2_resume_addr", imem_addr, 16'h0008);
      tick();
      chk("t2_pop2", dec_pc, 16'h0004);
      tick();
      chk("t2_pop3", dec_pc, 16'h0006);
      tick();
      chk("t2_pop4", dec_pc, 16'h0008);
      chk("t2_instr4", dec_instr, 16'h1008);
      // redirect with stale responses in flight, latency 3
      do_reset(3, 1'b0);
      ticks(5);
      chk("t3_occ_pre", occupancy, 2);
      chk("t3_head_pre", dec_pc, 16'h0000);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      dec_ready = 1'b1;
      #1;
      chk("t3_req_redir", imem_req, 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t3_flushed", occupancy, 0);
      chk("t3_nvalid", dec_valid, 0);
      chk("t3_drop_noreq", imem_req, 0);
      tick();
      chk("t3_req", imem_req, 1);
      chk("t3_addr", imem_addr, 16'h0040);
      ticks(3);
      chk("t3_nvalid2", dec_valid, 0);
      tick();
      chk("t3_valid", dec_valid, 1);
      chk("t3_pc", dec_pc, 16'h0040);
      chk("t3_instr", dec_instr, 16'h1040);
      // HLT stops fetch, redirect restarts it
      hlt_addr = 16'h0006;
      do_reset(1, 1'b1);
      ticks(5);
      chk("t4_halted", halted, 1);
      chk("t4_noreq", imem_req, 0);
      chk("t4_hlt_pc", dec_pc, 16'h0006);
      chk("t4_hlt_instr", dec_instr, 16'hF000);
      tick();
      chk("t4_behind", dec_pc, 16'h0008);
      chk("t4_noreq2", imem_req, 0);
      tick();
      chk("t4_empty", dec_valid, 0);
      chk("t4_noreq3", imem_req, 0);
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t4_unhalt", halted, 0);
      chk("t4_req", imem_req, 1);
      chk("t4_addr", imem_addr, 16'h0010);
      hlt_addr = 16'h0001;
      // PC wrap at the top of the address space
      do_reset(1, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFE;
      #1;
      chk("t5_req_redir", imem_req, 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("t5_addr_top", imem_addr, 16'hFFFE);
      tick();
      chk("t5_addr_wrap", imem_addr, 16'h0000);
      tick();
      chk("t5_pc", dec_pc, 16'hFFFE);
      chk("t5_inc", dec_pc_inc, 16'h0000);
      chk("t5_instr", dec_instr, 16'h1FFE);
      tick();
      chk("t5_pc_wrap", dec_pc, 16'h0000);
      // asynchronous reset mid-operation
      do_reset(1, 1'b0);
      ticks(4);
      chk("t6_occ_pre", occupancy, 3);
      rst = 1'b1;
      #1;
      chk("t6_req", imem_req, 0);
      chk("t6_valid", dec_valid, 0);
      chk("t6_occ", occupancy, 0);
      chk("t6_halted", halted, 0);
      chk("t6_instr", dec_instr, 0);
      chk("t6_pc", dec_pc, 0);
      do_reset(1, 1'b1);
      chk("t6_req_after", imem_req, 1);
      chk("t6_addr_after", imem_addr, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
